// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU, peripheral and memory sides of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
);
    // CPU (MEM stage) port
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Peripheral master port
    logic              per_req;
    logic              per_we;
    logic [ADDR_W-1:0] per_addr;
    logic [DATA_W-1:0] per_wdata;
    logic              per_ack;
    logic [DATA_W-1:0] per_rdata;

    // Single-port data memory
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        output cpu_rdata, cpu_stall,
        input  per_req, per_we, per_addr, per_wdata,
        output per_ack, per_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata
    );

    // CPU, peripheral and memory side (environment)
    modport master (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        input  cpu_rdata, cpu_stall,
        output per_req, per_we, per_addr, per_wdata,
        input  per_ack, per_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has priority, the peripheral gets a one-cycle
// slot when the CPU is idle or after a bounded wait, then a one-cycle ack.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 30,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_PER = 2'd1,
        S_ACK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               lat_we_q, lat_we_d;
    logic [ADDR_W-1:0]  lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]  lat_wdata_q, lat_wdata_d;
    logic               per_ack_q, per_ack_d;
    logic [DATA_W-1:0]  per_rdata_q, per_rdata_d;
    logic               cpu_acc_c;
    logic               grant_c;

    // CPU activity and peripheral grant decision
    always_comb begin
        cpu_acc_c = bus.cpu_rd | bus.cpu_wr;
        grant_c   = bus.per_req & (~cpu_acc_c | (wait_q == CNT_W'(STARVE_LIMIT)));
    end

    // State, wait counter, latched request and registered peripheral outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CPU;
            wait_q      <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            per_ack_q   <= 1'b0;
            per_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            per_ack_q   <= per_ack_d;
            per_rdata_q <= per_rdata_d;
        end
    end

    // Next-state logic; the ack flop is set on the S_PER -> S_ACK edge
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        per_ack_d   = 1'b0;
        per_rdata_d = per_rdata_q;
        case (state_q)
            S_CPU: begin
                if (grant_c) begin
                    state_d     = S_PER;
                    wait_d      = '0;
                    lat_we_d    = bus.per_we;
                    lat_addr_d  = bus.per_addr;
                    lat_wdata_d = bus.per_wdata;
                end else if (bus.per_req) begin
                    if (wait_q != CNT_W'(STARVE_LIMIT)) begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            S_PER: begin
                state_d   = S_ACK;
                per_ack_d = 1'b1;
                if (!lat_we_q) begin
                    per_rdata_d = bus.mem_rdata;
                end
            end
            S_ACK: begin
                state_d = S_CPU;
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    // Memory port mux and CPU-side responses
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_rd    = bus.cpu_rd;
        bus.mem_wr    = bus.cpu_wr;
        bus.cpu_rdata = bus.mem_rdata;
        bus.cpu_stall = 1'b0;
        if (state_q == S_PER) begin
            bus.mem_addr  = lat_addr_q;
            bus.mem_wdata = lat_wdata_q;
            bus.mem_rd    = ~lat_we_q;
            bus.mem_wr    = lat_we_q;
            bus.cpu_rdata = '0;
            bus.cpu_stall = cpu_acc_c;
        end
    end

    // Registered peripheral outputs
    always_comb begin
        bus.per_ack   = per_ack_q;
        bus.per_rdata = per_rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W    = 30;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LIMIT     = 4;
    localparam int unsigned MEM_WORDS = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT), .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Memory seen by the DUT, and the model's own copy of what it should hold
    logic [DATA_W-1:0] mem     [MEM_WORDS];
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];

    assign bus.mem_rdata = (bus.mem_addr < ADDR_W'(MEM_WORDS)) ? mem[bus.mem_addr[5:0]] : '0;

    int total = 0;
    int bad   = 0;

    // Model: a granted transaction occupies the next two cycles (slot, then ack)
    int                tx_age;
    int                waited;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_prdata;
    logic              m_ack_now;
    logic              obs_ack;
    logic              obs_stall;
    logic              req_active;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return (a < ADDR_W'(MEM_WORDS)) ? ref_mem[a[5:0]] : '0;
    endfunction

    task automatic ref_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (a < ADDR_W'(MEM_WORDS)) ref_mem[a[5:0]] = d;
    endtask

    task automatic model_reset();
        tx_age   = -1;
        waited   = 0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_prdata = '0;
    endtask

    task automatic check_outputs();
        logic slot;
        logic acc;
        slot      = reset && (tx_age == 1);
        m_ack_now = reset && (tx_age == 2);
        acc       = bus.cpu_rd | bus.cpu_wr;
        chk("mem_addr",  64'(bus.mem_addr),  slot ? 64'(m_addr)  : 64'(bus.cpu_addr));
        chk("mem_wdata", 64'(bus.mem_wdata), slot ? 64'(m_wdata) : 64'(bus.cpu_wdata));
        chk("mem_rd",    64'(bus.mem_rd),    slot ? 64'(!m_we)   : 64'(bus.cpu_rd));
        chk("mem_wr",    64'(bus.mem_wr),    slot ? 64'(m_we)    : 64'(bus.cpu_wr));
        chk("cpu_stall", 64'(bus.cpu_stall), 64'(slot & acc));
        chk("cpu_rdata", 64'(bus.cpu_rdata), slot ? 64'(0) : 64'(ref_rd(bus.cpu_addr)));
        chk("per_ack",   64'(bus.per_ack),   64'(m_ack_now));
        chk("per_rdata", 64'(bus.per_rdata), 64'(m_prdata));
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_step();
        logic acc;
        acc = bus.cpu_rd | bus.cpu_wr;
        if (!reset) begin
            model_reset();
            if (bus.cpu_wr) ref_wr(bus.cpu_addr, bus.cpu_wdata);
            return;
        end
        if (tx_age == 1) begin
            if (m_we) ref_wr(m_addr, m_wdata);
            else      m_prdata = ref_rd(m_addr);
        end else if (bus.cpu_wr) begin
            ref_wr(bus.cpu_addr, bus.cpu_wdata);
        end
        if (tx_age == 1) begin
            tx_age = 2;
        end else if (tx_age == 2) begin
            tx_age = -1;
        end else if (bus.per_req && (!acc || waited == int'(LIMIT))) begin
            m_we    = bus.per_we;
            m_addr  = bus.per_addr;
            m_wdata = bus.per_wdata;
            tx_age  = 1;
            waited  = 0;
        end else if (bus.per_req) begin
            waited = (waited < int'(LIMIT)) ? waited + 1 : waited;
        end else begin
            waited = 0;
        end
    endtask

    // One clock: check at the falling edge, commit memory writes at the rising edge
    task automatic cycle();
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              we;
        @(negedge clk);
        check_outputs();
        obs_ack   = bus.per_ack;
        obs_stall = bus.cpu_stall;
        wa = bus.mem_addr;
        wd = bus.mem_wdata;
        we = bus.mem_wr;
        model_step();
        @(posedge clk);
        if (we && wa < ADDR_W'(MEM_WORDS)) mem[wa[5:0]] = wd;
        #1;
    endtask

    task automatic set_cpu(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic set_per(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        bus.per_req   = req;
        bus.per_we    = we;
        bus.per_addr  = a;
        bus.per_wdata = d;
    endtask

    // Random CPU op plus a protocol-respecting peripheral master
    task automatic rand_inputs(input logic busy);
        int op;
        op = busy ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
        set_cpu(op == 1 || op == 3, op == 2, ADDR_W'($urandom_range(0, 70)), $urandom);
        if (req_active && m_ack_now) req_active = 1'b0;
        if (!req_active && $urandom_range(0, 2) == 0) begin
            req_active = 1'b1;
            set_per(1'b1, 1'(($urandom_range(0, 1))), ADDR_W'($urandom_range(0, 70)), $urandom);
        end else if (req_active && tx_age >= 1) begin
            set_per(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
        end else if (!req_active) begin
            set_per(1'b0, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
        end
    endtask

    initial begin
        int first;
        int acks;
        int consec;
        logic prev;
        logic busy;

        reset      = 1'b0;
        req_active = 1'b0;
        m_ack_now  = 1'b0;
        set_cpu(1'b0, 1'b0, '0, '0);
        set_per(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i]     = DATA_W'(i + 5);
            ref_mem[i] = DATA_W'(i + 5);
        end
        mem[3]     = 32'h0000_004F;
        ref_mem[3] = 32'h0000_004F;
        model_reset();

        // Reset with random inputs (no CPU stores)
        for (int i = 0; i < 3; i++) begin
            set_cpu(1'($urandom_range(0, 1)), 1'b0, ADDR_W'($urandom_range(0, 63)), $urandom);
            set_per(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 63)), $urandom);
            cycle();
            chk("rst_ack", 64'(obs_ack), 64'(0));
        end
        set_per(1'b0, 1'b0, '0, '0);
        set_cpu(1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        cycle();

        // Idle-CPU read of word 3
        set_per(1'b1, 1'b0, ADDR_W'(3), '0);
        first = -1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("idle_stall", 64'(obs_stall), 64'(0));
            if (obs_ack && first < 0) begin
                first = k;
                set_per(1'b0, 1'b0, '0, '0);
            end
        end
        chk("idle_ack_cycle", 64'(first), 64'(2));
        chk("idle_rdata", 64'(bus.per_rdata), 64'(32'h0000_004F));

        // Starvation: CPU reads word 5 every cycle, peripheral reads word 1
        set_cpu(1'b1, 1'b0, ADDR_W'(5), '0);
        set_per(1'b1, 1'b0, ADDR_W'(1), '0);
        first = -1;
        for (int k = 0; k < 10 && first < 0; k++) begin
            cycle();
            if (obs_stall) first = k;
        end
        chk("starve_slot_cycle", 64'(first), 64'(5));
        cycle();
        chk("starve_ack", 64'(obs_ack), 64'(1));
        set_per(1'b0, 1'b0, '0, '0);
        chk("starve_rdata", 64'(bus.per_rdata), 64'(32'h0000_0006));
        cycle();
        chk("starve_resume", 64'(bus.mem_addr), 64'(5));
        set_cpu(1'b0, 1'b0, '0, '0);

        // Peripheral write, then CPU read back of the same word
        set_per(1'b1, 1'b1, ADDR_W'(16), 32'hDEAD_BEEF);
        first = -1;
        for (int k = 0; k < 8 && first < 0; k++) begin
            cycle();
            if (obs_ack) first = k;
        end
        chk("wr_ack_cycle", 64'(first), 64'(2));
        set_per(1'b0, 1'b0, '0, '0);
        set_cpu(1'b1, 1'b0, ADDR_W'(16), '0);
        #1;
        chk("wr_readback", 64'(bus.cpu_rdata), 64'(32'hDEAD_BEEF));
        cycle();
        chk("wr_readback_stall", 64'(obs_stall), 64'(0));
        set_cpu(1'b0, 1'b0, '0, '0);

        // Held request for 10 cycles with an idle CPU
        set_per(1'b1, 1'b0, ADDR_W'(9), '0);
        acks   = 0;
        consec = 0;
        prev   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (obs_ack) acks++;
            if (obs_ack && prev) consec++;
            prev = obs_ack;
        end
        chk("held_acks", 64'(acks), 64'(3));
        chk("held_consec", 64'(consec), 64'(0));
        set_per(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) cycle();

        // Reset asserted while the peripheral owns the memory
        set_per(1'b1, 1'b1, ADDR_W'(20), 32'h1234_5678);
        cycle();
        chk("mid_in_slot", 64'(tx_age), 64'(1));
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ack", 64'(bus.per_ack), 64'(0));
        chk("mid_rst_rdata", 64'(bus.per_rdata), 64'(0));
        chk("mid_rst_mux", 64'(bus.mem_addr), 64'(bus.cpu_addr));
        set_per(1'b1, 1'b0, ADDR_W'(2), '0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("mid_rst_noack", 64'(obs_ack), 64'(0));
        end
        reset = 1'b1;
        first = -1;
        for (int k = 0; k < 8 && first < 0; k++) begin
            cycle();
            if (obs_ack) first = k;
        end
        chk("mid_regrant", 64'(first), 64'(2));
        chk("mid_regrant_rdata", 64'(bus.per_rdata), 64'(7));
        set_per(1'b0, 1'b0, '0, '0);
        cycle();

        // Randomized traffic with busy CPU bursts
        busy = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (n % 40 == 0) busy = 1'($urandom_range(0, 1));
            rand_inputs(busy);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and one peripheral master (PER port), e.g. a display scanner reading segment codes from words 0–15.
- The CPU has priority. The peripheral gets a one-cycle slot when the CPU is idle, or forcibly after a bounded wait.
- The memory read path is combinational and writes commit on the clock edge. The arbiter only multiplexes the memory port, generates the CPU stall and returns peripheral data registered.

Parameters:
ADDR_W, 30, word-address width
DATA_W, 32, data width
STARVE_LIMIT, 4, max cycles a pending PER request waits behind CPU traffic (range 1..7)
CNT_W, 3, wait-counter width; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rd  in  1  CPU load
cpu_wr  in  1  CPU store
cpu_rdata  out  DATA_W  load data to CPU
cpu_stall  out  1  CPU must hold its MEM-stage access this cycle
per_req  in  1  peripheral request, level, held until per_ack
per_we  in  1  1 = write, 0 = read; sampled with per_req
per_addr  in  ADDR_W  peripheral word address
per_wdata  in  DATA_W  peripheral write data
per_ack  out  1  one-cycle completion pulse
per_rdata  out  DATA_W  registered read data, valid when per_ack=1, held until next ack
mem_addr  out  ADDR_W  to memory Address
mem_wdata  out  DATA_W  to memory Write_data
mem_rd  out  1  to memory MemRead
mem_wr  out  1  to memory MemWrite
mem_rdata  in  DATA_W  from memory Read_data

Behaviour:
- States: S_CPU (CPU owns the memory), S_PER (peripheral owns the memory for exactly one cycle), S_ACK (acknowledge cycle; CPU owns the memory).
- Reset (reset=0, asynchronous):
  - state=S_CPU, wait_cnt=0, per_ack=0, per_rdata=0, latched PER request registers=0.
  - Reset asserted mid-S_PER or mid-S_ACK aborts the transaction: no ack is issued. A PER write in S_PER at the reset edge is not guaranteed.
- Memory port mux:
  - S_CPU/S_ACK: mem_* = cpu_addr, cpu_wdata, cpu_rd, cpu_wr; cpu_rdata = mem_rdata.
  - S_PER: mem_addr/mem_wdata come from the latched PER registers; mem_rd = ~lat_we; mem_wr = lat_we.
- cpu_stall = (state==S_PER) & (cpu_rd|cpu_wr); otherwise 0.
- cpu_rdata = 0 in S_PER.
- Grant condition, evaluated in S_CPU: grant = per_req & (~(cpu_rd|cpu_wr) | wait_cnt==STARVE_LIMIT).
- Transitions:
  - S_CPU → S_PER on grant. On that edge latch per_we/per_addr/per_wdata and clear wait_cnt.
  - S_PER → S_ACK unconditionally. On that edge per_rdata <= mem_rdata if the access was a read; unchanged if it was a write.
  - S_ACK → S_CPU unconditionally. per_ack=1 only while in S_ACK, registered and glitch-free.
- Wait counter:
  - In S_CPU with per_req=1 and no grant: wait_cnt increments, saturating at STARVE_LIMIT.
  - per_req=0 clears wait_cnt.
- Latency:
  - Idle CPU: per_req seen at edge T → S_PER for cycle T+1 → per_ack high for cycle T+2.
  - Busy CPU: the grant slips by at most STARVE_LIMIT cycles.
- Back-to-back requests:
  - per_req still high in S_ACK is not re-granted until S_CPU is re-entered.
  - Minimum ack spacing is therefore 3 cycles.
- Address range: addresses pass through unchanged. Out-of-range reads return whatever the memory returns (0). No decoding is done in the arbiter.
- Simultaneous CPU store and PER grant: the CPU store proceeds in the current S_CPU cycle. The PER slot begins next cycle, and the CPU is stalled only if it accesses memory during S_PER.
- Inputs per_we/per_addr/per_wdata may change after grant. The latched copies are used.

Test Plan:
- Reset: drive reset=0 with random inputs → per_ack=0, per_rdata=0x00000000, cpu_stall=0, mem_* follows the CPU port.
- Idle-CPU read: memory word 3 = 0x0000004F; per_req=1, per_we=0, per_addr=3 with cpu_rd=cpu_wr=0 → mem_addr=3 and mem_rd=1 one cycle later; per_ack=1 and per_rdata=0x0000004F the cycle after; cpu_stall stays 0.
- Starvation: cpu_rd=1 every cycle at addr 5, per_req held at addr 1 → four cycles without grant. The next cycle is S_PER: cpu_stall=1, cpu_rdata=0, mem_addr=1. Then ack with per_rdata=0x00000006. The CPU resumes at addr 5.
- PER write then CPU read: PER writes 0xDEADBEEF to addr 16, waits for ack, then CPU reads addr 16 → cpu_rdata=0xDEADBEEF with no stall.
- Held request: per_req kept at 1 for 10 cycles with an idle CPU → per_ack pulses every 3rd cycle, never on two consecutive cycles.
- Reset mid-transaction: reset=0 asserted during S_PER → per_ack never rises, per_rdata=0, state=S_CPU; re-arbitration restarts after reset=1.
